// File: rtl/aurora_hls_link_monitor.sv
// rtl/aurora_hls_link_monitor.sv - Aurora status / FIFO almost-full health monitor with saturating counters
// Optional run tracker (cur_run/max_run) enabled by defining AURORA_HLS_MONITOR_RUN_EN.
module aurora_hls_link_monitor #(
  parameter int                      STATUS_WIDTH = 13,
  parameter logic [STATUS_WIDTH-1:0] STATUS_OK    = 13'h11ff,
  parameter logic [STATUS_WIDTH-1:0] STATUS_MASK  = '1,
  parameter int                      NUM_FIFOS    = 2,
  parameter int                      CNT_WIDTH    = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [STATUS_WIDTH-1:0]        aurora_status,
  input  logic [NUM_FIFOS-1:0]           fifo_almost_full,
  input  logic                           clear,
  output logic                           status_ok,
  output logic [CNT_WIDTH-1:0]           core_status_not_ok_count,
  output logic [CNT_WIDTH-1:0]           core_status_drop_count,
  output logic [CNT_WIDTH-1:0]           core_status_max_run,
  output logic [NUM_FIFOS*CNT_WIDTH-1:0] fifo_overflow_count,
  output logic                           any_saturated
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic                 ok;
  logic                 prev_ok;
  logic [NUM_FIFOS-1:0] prev_af;
  logic [CNT_WIDTH-1:0] not_ok_q, not_ok_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic [CNT_WIDTH-1:0] ovf_q [NUM_FIFOS];
  logic [CNT_WIDTH-1:0] ovf_d [NUM_FIFOS];
  logic                 run_sat;
  logic                 sat_d;

  assign ok = ((aurora_status & STATUS_MASK) == (STATUS_OK & STATUS_MASK));

  always_comb begin
    not_ok_d = not_ok_q;
    drop_d   = drop_q;
    for (int i = 0; i < NUM_FIFOS; i++) ovf_d[i] = ovf_q[i];
    // clear wins over a same-cycle increment; edge history is kept
    if (clear) begin
      not_ok_d = '0;
      drop_d   = '0;
      for (int i = 0; i < NUM_FIFOS; i++) ovf_d[i] = '0;
    end else begin
      if (!ok) begin
        not_ok_d = sat_inc(not_ok_q);
        if (prev_ok) drop_d = sat_inc(drop_q);
      end
      for (int i = 0; i < NUM_FIFOS; i++) begin
        if (fifo_almost_full[i] && !prev_af[i]) ovf_d[i] = sat_inc(ovf_q[i]);
      end
    end
  end

  always_comb begin
    sat_d = (not_ok_d == CNT_MAX) || (drop_d == CNT_MAX) || run_sat;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      if (ovf_d[i] == CNT_MAX) sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_ok     <= 1'b0;
      prev_ok       <= 1'b1;
      prev_af       <= '0;
      not_ok_q      <= '0;
      drop_q        <= '0;
      any_saturated <= 1'b0;
      for (int i = 0; i < NUM_FIFOS; i++) ovf_q[i] <= '0;
    end else begin
      status_ok     <= ok;
      prev_ok       <= ok;
      prev_af       <= fifo_almost_full;
      not_ok_q      <= not_ok_d;
      drop_q        <= drop_d;
      any_saturated <= sat_d;
      for (int i = 0; i < NUM_FIFOS; i++) ovf_q[i] <= ovf_d[i];
    end
  end

  assign core_status_not_ok_count = not_ok_q;
  assign core_status_drop_count   = drop_q;

  for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_ovf_out
    assign fifo_overflow_count[g*CNT_WIDTH +: CNT_WIDTH] = ovf_q[g];
  end

`ifdef AURORA_HLS_MONITOR_RUN_EN
  logic [CNT_WIDTH-1:0] run_q, run_d, max_q, max_d, run_inc;

  always_comb begin
    run_inc = sat_inc(run_q);
    run_d   = run_q;
    max_d   = max_q;
    if (clear) begin
      run_d = '0;
      max_d = '0;
    end else if (!ok) begin
      run_d = run_inc;
      if (run_inc > max_q) max_d = run_inc;
    end else begin
      run_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= '0;
      max_q <= '0;
    end else begin
      run_q <= run_d;
      max_q <= max_d;
    end
  end

  // cur_run never exceeds max_run, so max_run alone covers saturation
  assign run_sat             = (max_d == CNT_MAX);
  assign core_status_max_run = max_q;
`else
  assign run_sat             = 1'b0;
  assign core_status_max_run = '0;
`endif

endmodule

// File: tb/tb_aurora_hls_link_monitor.sv
// tb/tb_aurora_hls_link_monitor.sv - directed self-checking bench for aurora_hls_link_monitor
module tb_aurora_hls_link_monitor;

  localparam logic [12:0] ST_OK  = 13'h11ff;
  localparam logic [12:0] ST_BAD = 13'h11fe;

`ifdef AURORA_HLS_MONITOR_RUN_EN
  localparam bit RUN_EN = 1'b1;
`else
  localparam bit RUN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default instance
  logic [12:0] a_status = ST_OK;
  logic [1:0]  a_flags  = 2'b00;
  logic        a_clear  = 1'b0;
  logic        a_ok, a_sat;
  logic [31:0] a_nok, a_drop, a_max;
  logic [63:0] a_ovf;

  // masked instance
  logic [12:0] m_status = 13'h01ff;
  logic        m_ok, m_sat;
  logic [31:0] m_nok, m_drop, m_max;
  logic [63:0] m_ovf;

  // 8-bit counter instance
  logic [12:0] s_status = ST_OK;
  logic        s_clear  = 1'b0;
  logic        s_ok, s_sat;
  logic [7:0]  s_nok, s_drop, s_max;
  logic [15:0] s_ovf;

  int checks = 0;
  int errors = 0;

  aurora_hls_link_monitor u_main (
    .clk(clk), .rst(rst), .aurora_status(a_status), .fifo_almost_full(a_flags),
    .clear(a_clear), .status_ok(a_ok), .core_status_not_ok_count(a_nok),
    .core_status_drop_count(a_drop), .core_status_max_run(a_max),
    .fifo_overflow_count(a_ovf), .any_saturated(a_sat));

  aurora_hls_link_monitor #(.STATUS_MASK(13'h00ff)) u_mask (
    .clk(clk), .rst(rst), .aurora_status(m_status), .fifo_almost_full(2'b00),
    .clear(1'b0), .status_ok(m_ok), .core_status_not_ok_count(m_nok),
    .core_status_drop_count(m_drop), .core_status_max_run(m_max),
    .fifo_overflow_count(m_ovf), .any_saturated(m_sat));

  aurora_hls_link_monitor #(.CNT_WIDTH(8)) u_sat (
    .clk(clk), .rst(rst), .aurora_status(s_status), .fifo_almost_full(2'b00),
    .clear(s_clear), .status_ok(s_ok), .core_status_not_ok_count(s_nok),
    .core_status_drop_count(s_drop), .core_status_max_run(s_max),
    .fifo_overflow_count(s_ovf), .any_saturated(s_sat));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] run_exp(input logic [63:0] v);
    return RUN_EN ? v : 64'd0;
  endfunction

  initial begin
    // reset held for two edges
    step();
    step();
    check("rst_status_ok", a_ok, 0);
    check("rst_nok", a_nok, 0);
    check("rst_drop", a_drop, 0);
    check("rst_max", a_max, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_sat", a_sat, 0);
    rst = 1'b0;
    step();
    check("rel_status_ok", a_ok, 1);
    check("rel_nok", a_nok, 0);
    check("mask_status_ok", m_ok, 1);
    check("mask_nok_zero", m_nok, 0);
    check("mask_drop_zero", m_drop, 0);

    // three not-OK cycles then OK
    a_status = ST_BAD;
    repeat (3) step();
    check("run1_status_ok", a_ok, 0);
    check("run1_nok", a_nok, 3);
    check("run1_drop", a_drop, 1);
    check("run1_max", a_max, run_exp(3));
    a_status = ST_OK;
    step();
    check("run1_ok_back", a_ok, 1);
    check("run1_nok_hold", a_nok, 3);
    a_status = ST_BAD;
    repeat (2) step();
    a_status = ST_OK;
    step();
    check("run2_nok", a_nok, 5);
    check("run2_drop", a_drop, 2);
    check("run2_max", a_max, run_exp(3));

    // flag pulses: flag0 twice, flag1 three times
    for (int k = 0; k < 3; k++) begin
      a_flags = {1'b1, (k < 2)};
      step();
      a_flags = 2'b00;
      step();
    end
    check("fifo0_pulses", a_ovf[31:0], 2);
    check("fifo1_pulses", a_ovf[63:32], 3);
    a_flags = 2'b01;
    repeat (5) step();
    a_flags = 2'b00;
    step();
    check("fifo0_held", a_ovf[31:0], 3);
    check("fifo1_unchanged", a_ovf[63:32], 3);

    // clear with flag0 held high: no recount afterwards
    a_flags = 2'b01;
    step();
    check("fifo0_pre_clear", a_ovf[31:0], 4);
    a_clear = 1'b1;
    step();
    a_clear = 1'b0;
    check("clr_nok", a_nok, 0);
    check("clr_drop", a_drop, 0);
    check("clr_max", a_max, 0);
    check("clr_ovf", a_ovf, 0);
    step();
    check("clr_fifo0_no_recount", a_ovf[31:0], 0);
    a_flags = 2'b00;

    // masked instance: upper bits ignored, low byte still checked
    m_status = ST_BAD;
    repeat (2) step();
    check("mask_bad_status_ok", m_ok, 0);
    check("mask_bad_nok", m_nok, 2);
    check("mask_bad_drop", m_drop, 1);

    // 8-bit saturation
    s_status = ST_BAD;
    repeat (254) step();
    check("sat_nok_254", s_nok, 254);
    check("sat_flag_254", s_sat, 0);
    step();
    check("sat_nok_255", s_nok, 255);
    check("sat_flag_255", s_sat, 1);
    repeat (45) step();
    check("sat_nok_300", s_nok, 255);
    check("sat_max_300", s_max, run_exp(255));
    check("sat_flag_300", s_sat, 1);
    s_clear = 1'b1;
    step();
    s_clear = 1'b0;
    check("sat_clr_nok", s_nok, 0);
    check("sat_clr_drop", s_drop, 0);
    check("sat_clr_flag", s_sat, 0);

    // asynchronous reset mid-run
    a_status = ST_BAD;
    repeat (2) step();
    check("pre_rst_nok", a_nok, 2);
    check("pre_rst_max", a_max, run_exp(2));
    rst = 1'b1;
    #1;
    check("arst_status_ok", a_ok, 0);
    check("arst_nok", a_nok, 0);
    check("arst_drop", a_drop, 0);
    check("arst_max", a_max, 0);
    check("arst_sat_nok", s_nok, 0);
    check("arst_sat_flag", a_sat, 0);
    a_status = ST_OK;
    a_flags  = 2'b10;
    step();
    rst = 1'b0;
    step();
    check("post_rst_fifo1", a_ovf[63:32], 1);
    check("post_rst_status_ok", a_ok, 1);
    step();
    check("post_rst_fifo1_hold", a_ovf[63:32], 1);
    check("post_rst_nok", a_nok, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
